pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Control block that drives the program counter's `jump_code`, `jump_address` and `return_address` inputs. It decodes a per-cycle flow-control op from the instruction decoder and maintains a hardware return-address stack for CALL/RET. It also implements stall, halt/resume and a sticky fault state for stack overflow and underflow. It sits between the decoder and the PC; the PC's `instruction_address` is fed back into it.

## Interface
- `INSTR_ADDR_SIZE`, default 5: width of instruction addresses; must match the PC.
- `STACK_DEPTH`, default 4: return-stack entries; power of two, ≥2.
- `CLK`  in  1: rising-edge clock, shared with the PC.
- `RST`  in  1: synchronous, active-high reset.
- `op`  in  3: flow op.
  - 0 STEP, 1 JUMP, 2 CALL, 3 RET, 4 HALT, 5 BRZ (jump if `cond`=0).
  - 6 and 7 are treated as STEP.
- `cond`  in  1: branch condition for BRZ.
- `target`  in  INSTR_ADDR_SIZE: destination for JUMP/CALL/BRZ.
- `instruction_address`  in  INSTR_ADDR_SIZE: current PC value (feedback).
- `stall`  in  1: hold PC this cycle, ignore `op`.
- `resume`  in  1: leave HALT.
- `jump_code`  out  5: PC command.
  - 0 RESET, 1 JUMP, 2 RET, 3 STEP (increment).
- `jump_address`  out  INSTR_ADDR_SIZE: address for jump_code JUMP.
- `return_address`  out  INSTR_ADDR_SIZE: top of stack, for jump_code RET.
- `depth`  out  $clog2(STACK_DEPTH)+1: number of valid stack entries.
- `halted`  out  1: state is HALT.
- `fault`  out  2: 00 none, 01 overflow, 10 underflow; sticky.

## Operation
- Registered state: `state` ∈ {RUN, HALT, FAULT}, stack pointer `sp`, stack array.
- RST=1: `jump_code`=RESET combinationally, so the PC clears on the same edge.
  - At that edge: `state`←RUN, `sp`←0, `fault`←00.
  - Stack contents are don't-care. RST overrides every other input, including mid-HALT and mid-FAULT.
- Outputs are combinational from `state`, `sp`, the top stack entry and the inputs.
- "Hold" means `jump_code`=JUMP with `jump_address`=`instruction_address`.
- Priority in RUN: RST > `stall` > `op`.
- RUN, `stall`=1: hold; no stack or state change.
- RUN, STEP: `jump_code`=STEP.
- RUN, JUMP: `jump_code`=JUMP, `jump_address`=`target`.
- RUN, BRZ: `cond`=0 behaves as JUMP; `cond`=1 behaves as STEP.
- RUN, CALL, `depth`<STACK_DEPTH:
  - `jump_code`=JUMP, `jump_address`=`target`.
  - At the edge, push `instruction_address`+1 mod 2^INSTR_ADDR_SIZE, then `sp`++.
- RUN, CALL, `depth`=STACK_DEPTH: hold; `fault`←01, `state`←FAULT; no push.
- RUN, RET, `depth`>0: `jump_code`=RET, `return_address`=top entry; `sp`-- at the edge.
- RUN, RET, `depth`=0: hold; `fault`←10, `state`←FAULT.
- RUN, HALT: hold; `state`←HALT.
- HALT:
  - Hold every cycle; `op` and `stall` are ignored.
  - `resume`=1: still hold this cycle, `state`←RUN at the edge, so execution continues at the next instruction in the following cycle.
  - The stack is preserved across HALT.
- FAULT: hold forever, ignore all inputs except RST.
- `return_address` when `depth`=0: drive all zeros.
- `halted`=1 only in HALT. `fault` is 00 unless the state is FAULT.

## Timing
- Zero-latency control: the op presented in cycle n determines the PC value after edge n.
- Stack push/pop and state updates take effect at the same edge as the PC update.
- Back-to-back CALL/RET at every cycle is supported with no bubbles.
- RET in the cycle immediately after CALL returns the just-pushed address.
- Reset values after the RST edge:
  - `depth`=0, `halted`=0, `fault`=00, `state`=RUN.
  - `jump_code`=0 for as long as RST is high.

## Test plan
- RST high for 2 cycles, then STEP ×3: PC goes 0,1,2,3; `jump_code`=0 during reset and 3 afterwards; `depth`=0.
- At PC=5, CALL `target`=20: PC=20 and `depth`=1. Then RET: `return_address`=6, PC=6, `depth`=0.
- INSTR_ADDR_SIZE=5, PC=31, CALL `target`=10: pushed value is 0. A later RET drives PC to 0 (wrap).
- STACK_DEPTH=4, 5 nested CALLs: the 5th holds PC and sets `fault`=01, FAULT persists for 10 cycles under random ops, and RST clears it. Separately, RET at `depth`=0 gives `fault`=10.
- HALT at PC=7: PC stays 7 and `halted`=1. Pulsing `resume` holds one more cycle, then STEP gives PC=8.
- `stall`=1 together with CALL at PC=3: PC stays 3 and `depth` is unchanged. BRZ `target`=12 with `cond`=0 gives PC=12; with `cond`=1 it gives PC+1.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Flow-control bus between the decoder/PC pair and the PC sequencer.
// The master side presents ops and the PC feedback; the slave side (the
// sequencer) returns the PC command, addresses and status.
interface pc_sequencer_if #(
   parameter int INSTR_ADDR_SIZE = 5,
   parameter int STACK_DEPTH     = 4
);
   localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

   logic [2:0]                 op;
   logic                       cond;
   logic [INSTR_ADDR_SIZE-1:0] target;
   logic [INSTR_ADDR_SIZE-1:0] instruction_address;
   logic                       stall;
   logic                       resume;
   logic [4:0]                 jump_code;
   logic [INSTR_ADDR_SIZE-1:0] jump_address;
   logic [INSTR_ADDR_SIZE-1:0] return_address;
   logic [DEPTH_W-1:0]         depth;
   logic                       halted;
   logic [1:0]                 fault;

   modport master (
      output op, cond, target, instruction_address, stall, resume,
      input  jump_code, jump_address, return_address, depth, halted, fault
   );

   modport slave (
      input  op, cond, target, instruction_address, stall, resume,
      output jump_code, jump_address, return_address, depth, halted, fault
   );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: decodes per-cycle flow ops into PC commands, keeps a
// return-address stack for CALL/RET, and implements stall, halt/resume
// and a sticky fault state for stack overflow/underflow.
module pc_sequencer #(
   parameter int INSTR_ADDR_SIZE = 5,
   parameter int STACK_DEPTH     = 4
) (
   input logic           CLK,
   input logic           RST,
   pc_sequencer_if.slave bus
);
   localparam int PTR_W   = $clog2(STACK_DEPTH);
   localparam int DEPTH_W = PTR_W + 1;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_HALT  = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   localparam logic [4:0] JC_RESET = 5'd0;
   localparam logic [4:0] JC_JUMP  = 5'd1;
   localparam logic [4:0] JC_RET   = 5'd2;
   localparam logic [4:0] JC_STEP  = 5'd3;

   localparam logic [2:0] OP_JUMP = 3'd1;
   localparam logic [2:0] OP_CALL = 3'd2;
   localparam logic [2:0] OP_RET  = 3'd3;
   localparam logic [2:0] OP_HALT = 3'd4;
   localparam logic [2:0] OP_BRZ  = 3'd5;

   localparam logic [1:0] FLT_NONE  = 2'b00;
   localparam logic [1:0] FLT_OVER  = 2'b01;
   localparam logic [1:0] FLT_UNDER = 2'b10;

   logic [1:0]                 state;
   logic [1:0]                 state_next;
   logic [1:0]                 fault_code;
   logic [1:0]                 fault_next;
   logic [DEPTH_W-1:0]         sp;
   logic                       push;
   logic                       pop;
   logic                       stack_full;
   logic                       stack_empty;
   logic [PTR_W-1:0]           top_idx;
   logic [INSTR_ADDR_SIZE-1:0] stack [STACK_DEPTH];

   assign stack_empty = (sp == '0);
   assign stack_full  = (sp == DEPTH_W'(STACK_DEPTH));
   // When the stack is full the low pointer bits wrap to zero, so minus one
   // still lands on the last entry.
   assign top_idx     = sp[PTR_W-1:0] - PTR_W'(1);

   assign bus.return_address = stack_empty ? '0 : stack[top_idx];
   assign bus.depth          = sp;
   assign bus.halted         = (state == ST_HALT);
   assign bus.fault          = (state == ST_FAULT) ? fault_code : FLT_NONE;

   // Decode the op into a PC command and the next state; default is a hold.
   always_comb begin
      bus.jump_code    = JC_JUMP;
      bus.jump_address = bus.instruction_address;
      push             = 1'b0;
      pop              = 1'b0;
      state_next       = state;
      fault_next       = fault_code;
      if (RST) begin
         bus.jump_code = JC_RESET;
      end else begin
         case (state)
            ST_RUN: begin
               if (!bus.stall) begin
                  case (bus.op)
                     OP_JUMP: begin
                        bus.jump_address = bus.target;
                     end
                     OP_CALL: begin
                        if (!stack_full) begin
                           bus.jump_address = bus.target;
                           push             = 1'b1;
                        end else begin
                           fault_next = FLT_OVER;
                           state_next = ST_FAULT;
                        end
                     end
                     OP_RET: begin
                        if (!stack_empty) begin
                           bus.jump_code = JC_RET;
                           pop           = 1'b1;
                        end else begin
                           fault_next = FLT_UNDER;
                           state_next = ST_FAULT;
                        end
                     end
                     OP_HALT: begin
                        state_next = ST_HALT;
                     end
                     OP_BRZ: begin
                        if (!bus.cond) begin
                           bus.jump_address = bus.target;
                        end else begin
                           bus.jump_code = JC_STEP;
                        end
                     end
                     default: begin
                        bus.jump_code = JC_STEP;
                     end
                  endcase
               end
            end
            ST_HALT: begin
               if (bus.resume) begin
                  state_next = ST_RUN;
               end
            end
            default: begin
               state_next = ST_FAULT;
            end
         endcase
      end
   end

   // Control state, fault code and stack pointer, all cleared by reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_RUN;
         fault_code <= FLT_NONE;
         sp         <= '0;
      end else begin
         state      <= state_next;
         fault_code <= fault_next;
         if (push) begin
            sp <= sp + DEPTH_W'(1);
         end else if (pop) begin
            sp <= sp - DEPTH_W'(1);
         end
      end
   end

   // Stack storage; contents need no reset since sp gates every read.
   always_ff @(posedge CLK) begin
      if (push) begin
         stack[sp[PTR_W-1:0]] <= bus.instruction_address + INSTR_ADDR_SIZE'(1);
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: a small PC driven by the DUT's commands,
// a queue-based behavioural model of the sequencer, and directed vectors
// with a few hand-computed literal pins.
module tb_pc_sequencer;
   localparam int A    = 5;
   localparam int D    = 4;
   localparam int AMOD = 1 << A;

   logic CLK = 1'b0;
   logic RST;
   logic [A-1:0] pc;

   always #5 CLK = ~CLK;

   pc_sequencer_if #(.INSTR_ADDR_SIZE(A), .STACK_DEPTH(D)) bus ();

   pc_sequencer #(.INSTR_ADDR_SIZE(A), .STACK_DEPTH(D)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   assign bus.instruction_address = pc;

   // Program counter obeying the sequencer's command
   always @(posedge CLK) begin
      case (bus.jump_code)
         5'd0:    pc <= '0;
         5'd1:    pc <= bus.jump_address;
         5'd2:    pc <= bus.return_address;
         5'd3:    pc <= pc + 1'b1;
         default: pc <= pc;
      endcase
   end

   // Model state: mode 0 run, 1 halt, 2 fault
   int mPc = 0;
   int mStack[$];
   int mMode = 0;
   int mFault = 0;
   bit modelValid = 0;
   int expCode;
   int expAddr;

   int compared = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      int expRet;
      expRet = (mStack.size() > 0) ? mStack[$] : 0;
      check("jump_code", 32'(bus.jump_code), expCode);
      if (expCode == 1) check("jump_address", 32'(bus.jump_address), expAddr);
      if (modelValid) begin
         check("return_address", 32'(bus.return_address), expRet);
         check("depth", 32'(bus.depth), mStack.size());
         check("halted", 32'(bus.halted), (mMode == 1) ? 1 : 0);
         check("fault", 32'(bus.fault), (mMode == 2) ? mFault : 0);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic [2:0] op, input logic cond,
                                input int tgt, input logic stall, input logic resume);
      int nPc;
      int nMode;
      int nFault;
      bit doPush;
      bit doPop;
      @(negedge CLK);
      RST        = rst;
      bus.op     = op;
      bus.cond   = cond;
      bus.target = tgt[A-1:0];
      bus.stall  = stall;
      bus.resume = resume;
      nPc = mPc; nMode = mMode; nFault = mFault; doPush = 0; doPop = 0;
      expCode = 1; expAddr = mPc;
      if (rst) begin
         expCode = 0; nPc = 0; nMode = 0; nFault = 0;
      end else if (mMode == 1) begin
         if (resume) nMode = 0;
      end else if (mMode == 0 && !stall) begin
         case (op)
            3'd1: begin expAddr = tgt; nPc = tgt; end
            3'd2: begin
               if (mStack.size() < D) begin
                  expAddr = tgt; nPc = tgt; doPush = 1;
               end else begin
                  nMode = 2; nFault = 1;
               end
            end
            3'd3: begin
               if (mStack.size() > 0) begin
                  expCode = 2; nPc = mStack[$]; doPop = 1;
               end else begin
                  nMode = 2; nFault = 2;
               end
            end
            3'd4: nMode = 1;
            3'd5: begin
               if (!cond) begin expAddr = tgt; nPc = tgt; end
               else begin expCode = 3; nPc = (mPc + 1) % AMOD; end
            end
            default: begin expCode = 3; nPc = (mPc + 1) % AMOD; end
         endcase
      end
      #2 checkOutput();
      @(posedge CLK);
      if (rst) mStack.delete();
      else if (doPush) mStack.push_back((mPc + 1) % AMOD);
      else if (doPop) void'(mStack.pop_back());
      mPc = nPc; mMode = nMode; mFault = nFault;
      if (rst) modelValid = 1;
      #1;
      if (modelValid) check("pc", 32'(pc), mPc);
   endtask

   task automatic doOp(input logic [2:0] op, input int tgt);
      applyStimulus(1'b0, op, 1'b0, tgt, 1'b0, 1'b0);
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 3'd0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      RST = 1'b1;
      bus.op = 3'd0; bus.cond = 1'b0; bus.target = '0; bus.stall = 1'b0; bus.resume = 1'b0;

      // Reset then STEP x3
      doReset();
      doReset();
      doOp(3'd0, 0); doOp(3'd0, 0); doOp(3'd0, 0);
      check("pin_step_pc", 32'(pc), 3);
      check("pin_step_depth", 32'(bus.depth), 0);

      // CALL at PC=5 and RET
      doOp(3'd1, 5);
      doOp(3'd2, 20);
      check("pin_call_pc", 32'(pc), 20);
      check("pin_call_depth", 32'(bus.depth), 1);
      check("pin_call_ret_addr", 32'(bus.return_address), 6);
      doOp(3'd3, 0);
      check("pin_ret_pc", 32'(pc), 6);
      check("pin_ret_depth", 32'(bus.depth), 0);

      // Return address wrap
      doOp(3'd1, 31);
      doOp(3'd2, 10);
      check("pin_wrap_ret_addr", 32'(bus.return_address), 0);
      doOp(3'd0, 0);
      doOp(3'd3, 0);
      check("pin_wrap_pc", 32'(pc), 0);

      // Overflow on the fifth nested CALL
      doOp(3'd2, 1); doOp(3'd2, 2); doOp(3'd2, 3); doOp(3'd2, 4);
      check("pin_full_depth", 32'(bus.depth), 4);
      doOp(3'd2, 9);
      check("pin_over_fault", 32'(bus.fault), 1);
      check("pin_over_pc", 32'(pc), 4);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
      end
      check("pin_fault_sticky", 32'(bus.fault), 1);
      check("pin_fault_pc", 32'(pc), 4);
      doReset();
      check("pin_fault_cleared", 32'(bus.fault), 0);
      check("pin_reset_depth", 32'(bus.depth), 0);

      // Underflow
      doOp(3'd3, 0);
      check("pin_under_fault", 32'(bus.fault), 2);
      doReset();

      // HALT and resume
      doOp(3'd1, 7);
      doOp(3'd4, 0);
      check("pin_halt_pc", 32'(pc), 7);
      check("pin_halted", 32'(bus.halted), 1);
      doOp(3'd0, 0);
      applyStimulus(1'b0, 3'd0, 1'b0, 0, 1'b0, 1'b1);
      check("pin_resume_pc", 32'(pc), 7);
      doOp(3'd0, 0);
      check("pin_after_resume_pc", 32'(pc), 8);

      // Reset while halted
      doOp(3'd4, 0);
      doReset();
      check("pin_halt_reset", 32'(bus.halted), 0);

      // Stall beats CALL, then BRZ both ways
      doOp(3'd1, 3);
      applyStimulus(1'b0, 3'd2, 1'b0, 20, 1'b1, 1'b0);
      check("pin_stall_pc", 32'(pc), 3);
      check("pin_stall_depth", 32'(bus.depth), 0);
      applyStimulus(1'b0, 3'd5, 1'b0, 12, 1'b0, 1'b0);
      check("pin_brz_taken", 32'(pc), 12);
      applyStimulus(1'b0, 3'd5, 1'b1, 20, 1'b0, 1'b0);
      check("pin_brz_not_taken", 32'(pc), 13);

      // Back-to-back CALL/RET
      doOp(3'd2, 25); doOp(3'd3, 0);
      doOp(3'd2, 30); doOp(3'd2, 2); doOp(3'd3, 0); doOp(3'd3, 0);
      check("pin_b2b_pc", 32'(pc), 15);
      check("pin_b2b_depth", 32'(bus.depth), 0);
      doOp(3'd6, 0);
      doOp(3'd7, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
